// File: rtl/mul16_seq_sched.sv
// mul16_seq_sched
// Sequential 16x16 unsigned multiplier built around a single 8x8 array
// multiplier. Each operand pair takes four partial-product passes, and the
// product is offered on a valid/ready output handshake. Results can be issued
// back to back at one product every five cycles.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand pair a/b is valid
//   in_ready   block accepts an operand pair this cycle
//   a, b       16-bit unsigned operands
//   abort      synchronous cancel of the operation in flight
//   out_valid  product p is valid
//   out_ready  consumer accepts p
//   p          32-bit unsigned product
//   busy       operation in flight (CALC or DONE)
//   op_count   number of products delivered, wrapping at 2^CNT_W
module mul16_seq_sched #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      a,
   input  logic [15:0]      b,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      p,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // The single shared 8x8 array multiplier.
   function automatic logic [15:0] mul8x8(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] prod;
      prod = 16'd0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) begin
            prod = prod + ({8'd0, x} << i);
         end else begin
            prod = prod;
         end
      end
      return prod;
   endfunction

   state_t             state;
   state_t             next_state;
   logic [1:0]         phase;
   logic [15:0]        a_reg;
   logic [15:0]        b_reg;
   logic [31:0]        acc;
   logic [CNT_W-1:0]   count;
   logic               handshake;
   logic               deliver;
   logic               calc_step;
   logic [7:0]         mul_a;
   logic [7:0]         mul_b;
   logic [15:0]        pp;
   logic [31:0]        pp_shifted;

   // Input acceptance: abort always blocks acceptance; DONE accepts only when the result drains.
   always_comb begin
      in_ready = 1'b0;
      if (abort) begin
         in_ready = 1'b0;
      end else if (state == IDLE) begin
         in_ready = 1'b1;
      end else if (state == DONE) begin
         in_ready = out_ready;
      end else begin
         in_ready = 1'b0;
      end
   end

   assign handshake = in_valid & in_ready;
   // A result is delivered only when abort is low (abort wins over out_ready).
   assign deliver   = (state == DONE) & out_ready & ~abort;
   assign calc_step = (state == CALC) & ~abort;

   // Partial-product operand selection and accumulator alignment by phase.
   always_comb begin
      mul_a      = phase[0] ? a_reg[15:8] : a_reg[7:0];
      mul_b      = phase[1] ? b_reg[15:8] : b_reg[7:0];
      pp         = mul8x8(mul_a, mul_b);
      pp_shifted = 32'd0;
      case (phase)
         2'd0:    pp_shifted = {16'd0, pp};
         2'd1:    pp_shifted = {8'd0, pp, 8'd0};
         2'd2:    pp_shifted = {8'd0, pp, 8'd0};
         2'd3:    pp_shifted = {pp, 16'd0};
         default: pp_shifted = 32'd0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (handshake) begin
               next_state = CALC;
            end else begin
               next_state = IDLE;
            end
         end
         CALC: begin
            if (abort) begin
               next_state = IDLE;
            end else if (phase == 2'd3) begin
               next_state = DONE;
            end else begin
               next_state = CALC;
            end
         end
         DONE: begin
            if (abort) begin
               next_state = IDLE;
            end else if (out_ready) begin
               // Handshake in DONE restarts immediately, no IDLE bubble.
               next_state = handshake ? CALC : IDLE;
            end else begin
               next_state = DONE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Operand capture, phase counter and accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= 16'd0;
         b_reg <= 16'd0;
         phase <= 2'd0;
         acc   <= 32'd0;
      end else if (handshake) begin
         a_reg <= a;
         b_reg <= b;
         phase <= 2'd0;
         acc   <= 32'd0;
      end else if (calc_step) begin
         phase <= phase + 2'd1;
         acc   <= acc + pp_shifted;
      end else begin
         phase <= phase;
         acc   <= acc;
      end
   end

   // Delivered-product counter, wrapping naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (deliver) begin
         count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign p         = acc;
   assign op_count  = count;

endmodule

// File: tb/tb_mul16_seq_sched.sv
// tb_mul16_seq_sched
// Self-checking bench for mul16_seq_sched. Two instances share the stimulus:
// the default CNT_W=16 one and a CNT_W=2 one used for counter wrap checks.
// Expected products come from plain a*b arithmetic; expected counts from an
// integer tally of delivered results.
module tb_mul16_seq_sched;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        abort;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;
   logic        busy;
   logic [15:0] op_count;

   logic        in_ready_s;
   logic        out_valid_s;
   logic [31:0] p_s;
   logic        busy_s;
   logic [1:0]  op_count_s;

   int          n_checks;
   int          n_errs;
   int          exp_cnt;

   mul16_seq_sched dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .abort(abort), .out_valid(out_valid),
      .out_ready(out_ready), .p(p), .busy(busy), .op_count(op_count)
   );

   mul16_seq_sched #(.CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .a(a), .b(b), .abort(abort), .out_valid(out_valid_s),
      .out_ready(out_ready), .p(p_s), .busy(busy_s), .op_count(op_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation: handshake, 4-edge latency, optional stall, drain.
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int hold);
      logic [31:0] e;
      e = {16'd0, x} * {16'd0, y};
      chk("rdy_idle", 32'(in_ready), 32'd1);
      a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
      chk("busy_calc", 32'(busy), 32'd1);
      chk("rdy_calc", 32'(in_ready), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("latency", 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
      end
      chk("product", p, e);
      chk("product_s", p_s, e);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_p", p, e);
         chk("hold_rdy", 32'(in_ready), 32'd0);
         chk("hold_cnt", 32'(op_count), 32'(exp_cnt % 65536));
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("rdy_done", 32'(in_ready), 32'd1);
      step();
      exp_cnt++;
      chk("op_count", 32'(op_count), 32'(exp_cnt % 65536));
      chk("op_count_s", 32'(op_count_s), 32'(exp_cnt % 4));
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [1:0] wrap_seq [5];
      logic [15:0] ra, rb;
      int   t_first;
      n_checks = 0; n_errs = 0; exp_cnt = 0;
      rst = 1'b1; in_valid = 1'b0; a = 16'd0; b = 16'd0;
      abort = 1'b0; out_ready = 1'b0;
      wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
      wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;

      // Reset state.
      step(); step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_p", p, 32'd0);
      chk("rst_cnt", 32'(op_count), 32'd0);
      rst = 1'b0;
      step();
      chk("rdy_after_rst", 32'(in_ready), 32'd1);

      // Directed products.
      run_op(16'h1234, 16'h5678, 0);
      chk("dir_cnt1", 32'(op_count), 32'd1);
      run_op(16'hFFFF, 16'hFFFF, 0);
      run_op(16'h0000, 16'hBEEF, 0);
      // Ten-cycle stall.
      run_op(16'h00A5, 16'h1F3C, 10);

      // abort in IDLE only blocks acceptance that cycle.
      abort = 1'b1; in_valid = 1'b1; a = 16'd7; b = 16'd9;
      #1;
      chk("abort_idle_rdy", 32'(in_ready), 32'd0);
      step();
      chk("abort_idle_busy", 32'(busy), 32'd0);
      abort = 1'b0; in_valid = 1'b0;
      #1;
      chk("abort_idle_rdy2", 32'(in_ready), 32'd1);

      // Back-to-back with in_valid held.
      a = 16'd3; b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
      step();
      a = 16'h00FF; b = 16'h0100;
      t_first = -1;
      for (int i = 1; i <= 12; i++) begin
         if (out_valid && t_first < 0) begin
            t_first = i - 1;
            chk("b2b_p1", p, 32'd15);
         end
         step();
         if (out_valid && t_first >= 0) begin
            chk("b2b_gap", 32'(i - 1 - t_first + 1), 32'd5);
            chk("b2b_p2", p, 32'h0000FF00);
            break;
         end
      end
      chk("b2b_first_lat", 32'(t_first), 32'd4);
      in_valid = 1'b0;
      step();
      exp_cnt += 2;
      chk("b2b_cnt", 32'(op_count), 32'(exp_cnt % 65536));

      // Randomised operations.
      for (int n = 0; n < 20; n++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         if (n == 0) ra = 16'hFFFF;
         run_op(ra, rb, int'($urandom_range(0, 3)));
      end

      // Abort during phase 2.
      a = 16'h4321; b = 16'h8765; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      abort = 1'b1;
      #1;
      chk("abort_rdy", 32'(in_ready), 32'd0);
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_cnt", 32'(op_count), 32'(exp_cnt % 65536));
      for (int i = 0; i < 6; i++) begin
         step();
         chk("abort_no_valid", 32'(out_valid), 32'd0);
      end

      // Reset pulse during CALC of a new operation.
      a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_p", p, 32'd0);
      chk("mid_rst_cnt", 32'(op_count), 32'd0);
      step();
      rst = 1'b0;
      exp_cnt = 0;
      step();
      chk("rdy_after_rst2", 32'(in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rst_no_valid", 32'(out_valid), 32'd0);
      end

      // Narrow counter wraps: 1, 2, 3, 0, 1.
      for (int n = 0; n < 5; n++) begin
         run_op(16'($urandom), 16'($urandom), 0);
         chk("wrap_seq", 32'(op_count_s), 32'(wrap_seq[n]));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/mul16_seq_sched.md
MUL16_SEQ_SCHED -- requirements
Module: mul16_seq_sched

Interface
REQ-001: The block SHALL have one parameter, CNT_W, default 16, giving the width of the completed-operation counter.
REQ-002: The ports SHALL be, in this order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  block accepts an operand pair this cycle.
- a  input  16  unsigned multiplicand.
- b  input  16  unsigned multiplier.
- abort  input  1  synchronous cancel of the operation in flight.
- out_valid  output  1  product p is valid.
- out_ready  input  1  consumer accepts p.
- p  output  32  unsigned product a*b.
- busy  output  1  operation in flight (CALC or DONE).
- op_count  output  CNT_W  number of products delivered, wrapping.
REQ-003: The block SHALL contain exactly one 8x8 unsigned combinational array multiplier (16-bit result), time-shared across all four partial products.

Function
REQ-004: The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-005: A handshake SHALL occur on a rising edge where in_valid and in_ready are both high; that edge SHALL capture a and b into internal registers, clear the 32-bit accumulator, set the 2-bit phase counter to 0, and enter CALC.
REQ-006: in_ready SHALL be high in IDLE, and in DONE when out_ready is high; it SHALL be low in CALC.
REQ-007: In CALC, the multiplier operands and the accumulator shift SHALL be selected by phase:
- phase 0: a[7:0] x b[7:0], shift 0.
- phase 1: a[15:8] x b[7:0], shift 8.
- phase 2: a[7:0] x b[15:8], shift 8.
- phase 3: a[15:8] x b[15:8], shift 16.
REQ-008: On each CALC edge, the accumulator SHALL be loaded with accumulator + (pp zero-extended to 32 bits, shifted left by the phase shift), modulo 2^32; the sum cannot overflow for unsigned 16x16 operands.
REQ-009: The phase counter SHALL increment on each CALC edge; the phase-3 edge SHALL enter DONE.
REQ-010: Latency SHALL be exactly 4 clock edges from the handshake edge to out_valid high, i.e. out_valid is asserted after the 4th edge.
REQ-011: out_valid SHALL be high only in DONE, and p SHALL equal the accumulator; p SHALL hold stable while out_valid is high and out_ready is low.
REQ-012: On an edge in DONE with out_ready high:
- op_count SHALL increment, wrapping from 2^CNT_W-1 to 0.
- If in_valid is also high, a new handshake SHALL occur (REQ-005) and the state SHALL go directly to CALC, giving one result per 5 cycles.
- Otherwise the state SHALL go to IDLE.
REQ-013: abort high on an edge in CALC or DONE SHALL return the FSM to IDLE, SHALL discard the result, and SHALL NOT increment op_count.
REQ-014: abort SHALL take priority over out_ready; in_ready SHALL be forced low in any cycle where abort is high.
REQ-015: abort in IDLE SHALL have no effect other than blocking acceptance in that cycle.
REQ-016: busy SHALL be high exactly when the state is CALC or DONE.
REQ-017: In IDLE and CALC, p SHALL be driven with the current accumulator value; consumers SHALL qualify p with out_valid.
REQ-018: Operand registers SHALL change only on a handshake edge; a and b are don't-care at all other times.

Reset
REQ-019: When rst is asserted, the block SHALL immediately and asynchronously set the state to IDLE.
REQ-020: Reset SHALL clear the phase counter, the accumulator, the operand registers and op_count to 0.
REQ-021: During reset, out_valid SHALL be 0, busy SHALL be 0 and p SHALL be 0.
REQ-022: rst asserted mid-operation SHALL discard the operation.
REQ-023: in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-024: The bench SHALL cover these directed scenarios:
- a=0x1234, b=0x5678, out_ready=1 -> out_valid after exactly 4 edges, p=0x06260060, op_count=1.
- a=0xFFFF, b=0xFFFF -> p=0xFFFE0001; a=0x0000, b=0xBEEF -> p=0x00000000.
- out_ready=0 for 10 cycles after out_valid -> p and out_valid held, in_ready=0, op_count unchanged; then out_ready=1 -> op_count increments once.
- Back-to-back: in_valid held with pairs (3,5), (0x00FF, 0x0100) -> p=15, then p=0x0000FF00, results 5 cycles apart.
- abort during phase 2, then rst pulse during CALC of a new operation -> no out_valid, op_count unchanged by abort and 0 after rst, in_ready=1 after rst release.
- CNT_W=2, 5 completed operations -> op_count sequence 1, 2, 3, 0, 1.
